// File: rtl/alu_system.sv
// alu_system: register file, address register file, instruction register,
// 256x8 memory, three source muxes and an 8-bit ALU with registered flags.
// The ALU and every read port are combinational; all state moves on the
// rising edge of Clock, and Reset is synchronous and active-low.
module alu_system (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [1:0]  RF_FunSel,
  input  logic [3:0]  RF_RSel,
  input  logic [3:0]  RF_TSel,
  input  logic [3:0]  ALU_FunSel,
  input  logic [1:0]  ARF_OutCSel,
  input  logic [1:0]  ARF_OutDSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [3:0]  ARF_RegSel,
  input  logic        IR_LH,
  input  logic        IR_Enable,
  input  logic [1:0]  IR_Funsel,
  input  logic        Mem_WR,
  input  logic        Mem_CS,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic        MuxCSel,
  output logic [7:0]  AOut,
  output logic [7:0]  BOut,
  output logic [7:0]  ALUOut,
  output logic [3:0]  ALUOutFlag,
  output logic [7:0]  ARF_AOut,
  output logic [7:0]  Address,
  output logic [7:0]  MemoryOut,
  output logic [15:0] IROut,
  output logic [7:0]  MuxAOut,
  output logic [7:0]  MuxBOut,
  output logic [7:0]  MuxCOut
);

  // Arrays are stored so that enable bit i drives entry i:
  // r_r[3]=R1 .. r_r[0]=R4, r_t[3]=T1 .. r_t[0]=T4,
  // r_arf[3]=PC, [2]=AR, [1]=SP, [0]=PCPast.
  // A 2-bit read select s therefore maps to entry ~s.
  logic [7:0]  r_r   [3:0];
  logic [7:0]  r_t   [3:0];
  logic [7:0]  r_arf [3:0];
  logic [15:0] r_ir;
  logic [7:0]  r_mem [0:255];
  logic        r_z, r_c, r_n, r_o;

  logic [1:0]  w_a_idx, w_b_idx, w_c_idx, w_d_idx;
  logic [8:0]  w_sum;
  logic        w_c_nxt, w_o_nxt;

  function automatic logic [7:0] f_upd8(input logic [1:0] fs,
                                        input logic [7:0] cur,
                                        input logic [7:0] din);
    case (fs)
      2'b00:   f_upd8 = cur - 8'd1;
      2'b01:   f_upd8 = cur + 8'd1;
      2'b10:   f_upd8 = din;
      default: f_upd8 = 8'd0;
    endcase
  endfunction

  assign w_a_idx = ~RF_OutASel[1:0];
  assign w_b_idx = ~RF_OutBSel[1:0];
  assign w_c_idx = ~ARF_OutCSel;
  assign w_d_idx = ~ARF_OutDSel;

  // Combinational read ports of RF, ARF, IR, memory and flags
  always_comb begin
    AOut       = RF_OutASel[2] ? r_r[w_a_idx] : r_t[w_a_idx];
    BOut       = RF_OutBSel[2] ? r_r[w_b_idx] : r_t[w_b_idx];
    ARF_AOut   = r_arf[w_c_idx];
    Address    = r_arf[w_d_idx];
    IROut      = r_ir;
    MemoryOut  = (!Mem_CS && !Mem_WR) ? r_mem[Address] : 8'd0;
    ALUOutFlag = {r_z, r_c, r_n, r_o};
  end

  // Source muxes feeding the RF, the ARF and the ALU A input
  always_comb begin
    case (MuxASel)
      2'b00:   MuxAOut = ALUOut;
      2'b01:   MuxAOut = MemoryOut;
      2'b10:   MuxAOut = IROut[7:0];
      default: MuxAOut = ARF_AOut;
    endcase
    case (MuxBSel)
      2'b00:   MuxBOut = ALUOut;
      2'b01:   MuxBOut = MemoryOut;
      2'b10:   MuxBOut = IROut[7:0];
      default: MuxBOut = ARF_AOut;
    endcase
    MuxCOut = MuxCSel ? ARF_AOut : AOut;
  end

  // ALU result and next carry/overflow; C and O hold unless the op defines them
  always_comb begin
    w_sum   = 9'd0;
    ALUOut  = 8'd0;
    w_c_nxt = r_c;
    w_o_nxt = r_o;
    case (ALU_FunSel)
      4'b0000: ALUOut = MuxCOut;
      4'b0001: ALUOut = BOut;
      4'b0010: ALUOut = ~MuxCOut;
      4'b0011: ALUOut = ~BOut;
      4'b0100: begin
        w_sum   = {1'b0, MuxCOut} + {1'b0, BOut};
        ALUOut  = w_sum[7:0];
        w_c_nxt = w_sum[8];
        w_o_nxt = (MuxCOut[7] == BOut[7]) && (ALUOut[7] != MuxCOut[7]);
      end
      4'b0101: begin
        w_sum   = {1'b0, MuxCOut} + {1'b0, BOut} + {8'd0, r_c};
        ALUOut  = w_sum[7:0];
        w_c_nxt = w_sum[8];
        w_o_nxt = (MuxCOut[7] == BOut[7]) && (ALUOut[7] != MuxCOut[7]);
      end
      4'b0110: begin
        w_sum   = {1'b0, MuxCOut} + {1'b0, ~BOut} + 9'd1;
        ALUOut  = w_sum[7:0];
        w_c_nxt = w_sum[8];
        w_o_nxt = (MuxCOut[7] != BOut[7]) && (ALUOut[7] != MuxCOut[7]);
      end
      4'b0111: ALUOut = MuxCOut & BOut;
      4'b1000: ALUOut = MuxCOut | BOut;
      4'b1001: ALUOut = MuxCOut ^ BOut;
      4'b1010: begin
        ALUOut  = {MuxCOut[6:0], 1'b0};
        w_c_nxt = MuxCOut[7];
      end
      4'b1011: begin
        ALUOut  = {1'b0, MuxCOut[7:1]};
        w_c_nxt = MuxCOut[0];
      end
      4'b1100: begin
        ALUOut  = {MuxCOut[6:0], 1'b0};
        w_c_nxt = MuxCOut[7];
        w_o_nxt = MuxCOut[7] ^ ALUOut[7];
      end
      4'b1101: begin
        ALUOut  = {MuxCOut[7], MuxCOut[7:1]};
        w_c_nxt = MuxCOut[0];
      end
      4'b1110: begin
        ALUOut  = {MuxCOut[6:0], r_c};
        w_c_nxt = MuxCOut[7];
      end
      default: begin
        ALUOut  = {r_c, MuxCOut[7:1]};
        w_c_nxt = MuxCOut[0];
      end
    endcase
  end

  // Register file, ARF, IR and flag state with synchronous reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_r[i]   <= 8'd0;
        r_t[i]   <= 8'd0;
        r_arf[i] <= 8'd0;
      end
      r_ir <= 16'd0;
      r_z  <= 1'b0;
      r_c  <= 1'b0;
      r_n  <= 1'b0;
      r_o  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (RF_RSel[i])    r_r[i]   <= f_upd8(RF_FunSel, r_r[i], MuxAOut);
        if (RF_TSel[i])    r_t[i]   <= f_upd8(RF_FunSel, r_t[i], MuxAOut);
        if (ARF_RegSel[i]) r_arf[i] <= f_upd8(ARF_FunSel, r_arf[i], MuxBOut);
      end
      if (IR_Enable) begin
        case (IR_Funsel)
          2'b00: r_ir <= r_ir - 16'd1;
          2'b01: r_ir <= r_ir + 16'd1;
          2'b10: begin
            if (IR_LH) r_ir[15:8] <= MemoryOut;
            else       r_ir[7:0]  <= MemoryOut;
          end
          default: r_ir <= 16'd0;
        endcase
      end
      r_z <= (ALUOut == 8'd0);
      r_n <= ALUOut[7];
      r_c <= w_c_nxt;
      r_o <= w_o_nxt;
    end
  end

  // Memory write port; contents survive reset
  always_ff @(posedge Clock) begin
    if (!Mem_CS && Mem_WR) r_mem[Address] <= ALUOut;
  end

endmodule

// File: tb/tb_alu_system.sv
// Directed bench for alu_system: hand-computed vectors for RF/ARF/IR
// updates, memory write/read, muxes, ALU ops and the flag register.
module tb_alu_system;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [7:0]  AOut, BOut, ALUOut, ARF_AOut, Address, MemoryOut;
  logic [3:0]  ALUOutFlag;
  logic [15:0] IROut;
  logic [7:0]  MuxAOut, MuxBOut, MuxCOut;

  int n_checks = 0;
  int n_errors = 0;

  alu_system dut (
    .Clock(Clock), .Reset(Reset),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel),
    .RF_FunSel(RF_FunSel), .RF_RSel(RF_RSel), .RF_TSel(RF_TSel),
    .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
    .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .AOut(AOut), .BOut(BOut), .ALUOut(ALUOut), .ALUOutFlag(ALUOutFlag),
    .ARF_AOut(ARF_AOut), .Address(Address), .MemoryOut(MemoryOut),
    .IROut(IROut),
    .MuxAOut(MuxAOut), .MuxBOut(MuxBOut), .MuxCOut(MuxCOut)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    RF_RSel = 4'b0000; RF_TSel = 4'b0000; RF_FunSel = 2'b00;
    ARF_RegSel = 4'b0000; ARF_FunSel = 2'b00;
    IR_Enable = 1'b0; IR_LH = 1'b0; IR_Funsel = 2'b00;
    Mem_CS = 1'b1; Mem_WR = 1'b0;
  endtask

  initial begin
    idle();
    RF_OutASel = 3'b000; RF_OutBSel = 3'b000;
    ARF_OutCSel = 2'b00; ARF_OutDSel = 2'b00;
    ALU_FunSel = 4'b0000;
    MuxASel = 2'b00; MuxBSel = 2'b00; MuxCSel = 1'b0;

    // Reset with enables active: reset must win
    Reset = 1'b0;
    RF_RSel = 4'b1111; RF_TSel = 4'b1111; RF_FunSel = 2'b01;
    IR_Enable = 1'b1; IR_Funsel = 2'b01;
    tick();
    tick();
    idle();
    Reset = 1'b1;
    #1;
    chk("rst_aout", 16'(AOut), 16'h00);
    chk("rst_bout", 16'(BOut), 16'h00);
    chk("rst_addr", 16'(Address), 16'h00);
    chk("rst_ir", IROut, 16'h0000);
    chk("rst_flags", 16'(ALUOutFlag), 16'h0);

    // R1 increment x3, then decrement x4 wraps to FF
    RF_OutASel = 3'b100; RF_OutBSel = 3'b101;
    RF_RSel = 4'b1000; RF_FunSel = 2'b01;
    repeat (3) tick();
    chk("r1_inc3", 16'(AOut), 16'h03);
    RF_FunSel = 2'b00;
    repeat (4) tick();
    chk("r1_dec_wrap", 16'(AOut), 16'hFF);
    chk("r2_held", 16'(BOut), 16'h00);

    // R1 <= LSR(FF) = 7F through MuxA
    RF_FunSel = 2'b10; MuxASel = 2'b00; ALU_FunSel = 4'b1011;
    #1;
    chk("lsr_ff", 16'(ALUOut), 16'h7F);
    tick();
    chk("r1_load", 16'(AOut), 16'h7F);
    chk("flags_lsr", 16'(ALUOutFlag), 16'b0100);

    // R2 <= 01
    ALU_FunSel = 4'b0000;
    RF_RSel = 4'b0100; RF_FunSel = 2'b01;
    tick();
    chk("r2_inc", 16'(BOut), 16'h01);

    // 7F + 01 = 80, overflow; also captured into T1
    RF_RSel = 4'b0000; RF_TSel = 4'b1000; RF_FunSel = 2'b10;
    ALU_FunSel = 4'b0100;
    #1;
    chk("add_7f_01", 16'(ALUOut), 16'h80);
    chk("muxa_alu", 16'(MuxAOut), 16'h80);
    tick();
    chk("flags_add", 16'(ALUOutFlag), 16'b0011);

    // T1 <= LSR(80) = 40; then AR <= LSR(40) = 20 via MuxB
    RF_OutASel = 3'b000; ALU_FunSel = 4'b1011;
    tick();
    chk("t1_lsr", 16'(AOut), 16'h40);
    chk("flags_lsr80", 16'(ALUOutFlag), 16'b0001);
    RF_TSel = 4'b0000;
    ARF_RegSel = 4'b0100; ARF_FunSel = 2'b10; MuxBSel = 2'b00;
    #1;
    chk("muxb_alu", 16'(MuxBOut), 16'h20);
    tick();
    ARF_RegSel = 4'b0000;
    ARF_OutDSel = 2'b01; ARF_OutCSel = 2'b01;
    #1;
    chk("ar_addr", 16'(Address), 16'h20);
    chk("ar_outc", 16'(ARF_AOut), 16'h20);

    // R2: 01 + 89 = 5A
    ALU_FunSel = 4'b0000;
    RF_RSel = 4'b0100; RF_FunSel = 2'b01;
    repeat (89) tick();
    RF_RSel = 4'b0000;

    // Write 5A to mem[20], read it back, load IR high then low
    ALU_FunSel = 4'b0001;
    Mem_CS = 1'b0; Mem_WR = 1'b1;
    #1;
    chk("alu_passb", 16'(ALUOut), 16'h5A);
    chk("mem_wr_out0", 16'(MemoryOut), 16'h00);
    tick();
    Mem_WR = 1'b0; MuxASel = 2'b01;
    #1;
    chk("mem_read", 16'(MemoryOut), 16'h5A);
    chk("muxa_mem", 16'(MuxAOut), 16'h5A);
    IR_Enable = 1'b1; IR_LH = 1'b1; IR_Funsel = 2'b10;
    tick();
    chk("ir_load_hi", IROut, 16'h5A00);
    IR_Funsel = 2'b01;
    tick();
    chk("ir_inc", IROut, 16'h5A01);
    IR_LH = 1'b0; IR_Funsel = 2'b10;
    tick();
    chk("ir_load_lo", IROut, 16'h5A5A);
    IR_Enable = 1'b0; MuxBSel = 2'b10; Mem_CS = 1'b1;
    #1;
    chk("muxb_ir", 16'(MuxBOut), 16'h5A);
    chk("mem_cs_off", 16'(MemoryOut), 16'h00);

    // C=1 from LSR(7F) while PC counts to 02
    RF_OutASel = 3'b100; MuxCSel = 1'b0; ALU_FunSel = 4'b1011;
    ARF_RegSel = 4'b1000; ARF_FunSel = 2'b01;
    repeat (2) tick();
    ARF_RegSel = 4'b0000;
    chk("flags_c1", 16'(ALUOutFlag), 16'b0101);

    // Rotate right through carry: C=1, A=02 -> 81, C=0, N=1
    MuxCSel = 1'b1; ARF_OutCSel = 2'b00; ALU_FunSel = 4'b1111;
    #1;
    chk("muxc_arf", 16'(MuxCOut), 16'h02);
    chk("ror_c", 16'(ALUOut), 16'h81);
    tick();
    chk("flags_ror", 16'(ALUOutFlag), 16'b0011);

    // 7F - 5A = 25 with carry out; then 7F + 5A + C = DA, overflow
    MuxCSel = 1'b0; RF_OutBSel = 3'b101; ALU_FunSel = 4'b0110;
    #1;
    chk("sub", 16'(ALUOut), 16'h25);
    tick();
    chk("flags_sub", 16'(ALUOutFlag), 16'b0100);
    ALU_FunSel = 4'b0101;
    #1;
    chk("adc", 16'(ALUOut), 16'hDA);
    tick();
    chk("flags_adc", 16'(ALUOutFlag), 16'b0011);

    // PC 02 -> FF by three decrements; ASR, ASL, NOT on FF
    ALU_FunSel = 4'b0000;
    ARF_RegSel = 4'b1000; ARF_FunSel = 2'b00;
    repeat (3) tick();
    ARF_RegSel = 4'b0000;
    MuxCSel = 1'b1; ALU_FunSel = 4'b1101;
    #1;
    chk("asr_ff", 16'(ALUOut), 16'hFF);
    tick();
    chk("flags_asr", 16'(ALUOutFlag), 16'b0111);
    ALU_FunSel = 4'b1100;
    #1;
    chk("asl_ff", 16'(ALUOut), 16'hFE);
    tick();
    chk("flags_asl", 16'(ALUOutFlag), 16'b0110);
    ALU_FunSel = 4'b0010;
    #1;
    chk("not_ff", 16'(ALUOut), 16'h00);
    tick();
    chk("flags_zero", 16'(ALUOutFlag), 16'b1100);

    // Second reset clears state
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    RF_OutASel = 3'b100; ARF_OutDSel = 2'b01;
    #1;
    chk("rst2_r1", 16'(AOut), 16'h00);
    chk("rst2_ir", IROut, 16'h0000);
    chk("rst2_ar", 16'(Address), 16'h00);
    chk("rst2_flags", 16'(ALUOutFlag), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_system.md
ALU_SYSTEM -- requirements
Module: alu_system

Interface
REQ-001 Clock  in  1  SHALL be the rising-edge clock for all state.
REQ-002 Reset  in  1  SHALL be the reset: synchronous, active-low.
REQ-003 RF_OutASel  in  3  SHALL select the register-file register driving AOut.
REQ-004 RF_OutBSel  in  3  SHALL select the register-file register driving BOut.
REQ-005 RF_FunSel  in  2  SHALL be the register-file operation code.
REQ-006 RF_RSel  in  4  SHALL hold the R1..R4 enables (bit3=R1).
REQ-007 RF_TSel  in  4  SHALL hold the T1..T4 enables (bit3=T1).
REQ-008 ALU_FunSel  in  4  SHALL be the ALU operation code.
REQ-009 ARF_OutCSel  in  2  SHALL select the address-register-file register driving ARF_AOut.
REQ-010 ARF_OutDSel  in  2  SHALL select the address-register-file register driving Address.
REQ-011 ARF_FunSel  in  2  SHALL be the address-register-file operation code.
REQ-012 ARF_RegSel  in  4  SHALL hold the enables (bit3=PC, bit2=AR, bit1=SP, bit0=PCPast).
REQ-013 IR_LH  in  1  SHALL select the IR load half (0 low, 1 high).
REQ-014 IR_Enable  in  1  SHALL be the IR enable (active high).
REQ-015 IR_Funsel  in  2  SHALL be the IR operation code.
REQ-016 Mem_WR  in  1  SHALL select memory direction (1 write, 0 read).
REQ-017 Mem_CS  in  1  SHALL be the memory chip select (active-low).
REQ-018 MuxASel / MuxBSel  in  2 each  SHALL be the RF-input and ARF-input mux selects.
REQ-019 MuxCSel  in  1  SHALL be the ALU A-input mux select.
REQ-020 AOut, BOut  out  8 each  SHALL be the register-file read ports.
REQ-021 ALUOut  out  8  SHALL be the combinational ALU result.
REQ-022 ALUOutFlag  out  4  SHALL be the registered flags {Z,C,N,O}.
REQ-023 ARF_AOut, Address  out  8 each  SHALL be the ARF OutC and OutD ports.
REQ-024 MemoryOut  out  8  SHALL be the memory read data.
REQ-025 IROut  out  16  SHALL be the instruction register.
REQ-026 MuxAOut, MuxBOut, MuxCOut  out  8 each  SHALL be the mux outputs.

Function
REQ-027 Every FunSel (RF, ARF, IR) SHALL act on enabled registers only, at the rising edge: 00 decrement, 01 increment, 10 load, 11 clear. Arithmetic wraps modulo width; disabled registers hold.
REQ-028 The register file SHALL hold 8-bit R1-R4 and T1-T4 and load from MuxAOut. Reads are combinational: 000-011 select T1-T4; 100-111 select R1-R4.
REQ-029 The ARF SHALL hold 8-bit PC, AR, SP and PCPast and load from MuxBOut. OutC/OutD reads are combinational: 00 PC, 01 AR, 10 SP, 11 PCPast.
REQ-030 IR load SHALL write MemoryOut into IR[7:0] (LH=0) or IR[15:8] (LH=1), holding the other half. Increment, decrement and clear SHALL act on all 16 bits.
REQ-031 Memory SHALL be 256x8, addressed by Address, with data-in = ALUOut.
- CS=0, WR=0: MemoryOut = mem[Address], combinational.
- CS=0, WR=1: write at the rising edge; MemoryOut = 0.
- CS=1: no access; MemoryOut = 0.
- Power-up contents are 0.
REQ-032 MuxA and MuxB SHALL select: 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_AOut. MuxC SHALL select 0 AOut, 1 ARF_AOut. ALU A = MuxCOut; ALU B = BOut.
REQ-033 ALU ops SHALL be: 0000 A; 0001 B; 0010 ~A; 0011 ~B; 0100 A+B; 0101 A+B+C; 0110 A-B (=A+~B+1); 0111 AND; 1000 OR; 1001 XOR; 1010 LSL A; 1011 LSR A; 1100 ASL A; 1101 ASR A (sign kept); 1110 rotate A left through C; 1111 rotate A right through C.
REQ-034 Flags SHALL update at every rising edge:
- Z = (ALUOut==0) and N = ALUOut[7] for all ops.
- C = carry-out for 0100/0101/0110, and the shifted-out bit for 1010-1111; otherwise hold.
- O = signed overflow for 0100/0101/0110, and A[7]^ALUOut[7] for ASL; otherwise hold.
REQ-035 A register read and written in the same cycle SHALL return the old value until the edge. Combinational paths (RF->ALU->MuxA->RF) SHALL settle within one cycle.

Reset
REQ-036 Reset=0 at a rising edge SHALL zero all RF, ARF, IR and flag state, overriding all selects. Memory is unchanged. AOut, BOut, ARF_AOut, Address and IROut then read 0, and ALUOutFlag reads 0000.

Verification
REQ-037 Hold Reset=0 for one edge -> AOut=BOut=Address=0, IROut=0x0000, ALUOutFlag=0000.
REQ-038 RF_RSel=1000, RF_FunSel=01 for 3 edges, OutASel=100 -> AOut=0x03. Then FunSel=00 for 4 edges -> 0xFF (wrap).
REQ-039 R1=0x7F, R2=0x01, OutA=R1, OutB=R2, MuxCSel=0, ALU 0100 -> ALUOut=0x80, and after the edge flags = 0011 (Z0 C0 N1 O1).
REQ-040 AR=0x20 and ALUOut=0x5A, CS=0 WR=1 for one edge; then WR=0 with OutDSel=01 -> MemoryOut=0x5A. Then IR_Enable=1, LH=1, Funsel=10 -> IROut=0x5A00.
REQ-041 With C=1, A=0x02, ALU 1111 -> ALUOut=0x81, and after the edge C=0, N=1.
